// File: rtl/rscpu_pkg.sv
// Shared types and constants for the accumulator CPU datapath.
// The optional carry flag is enabled by defining RSCPU_CARRY_FLAG_EN.
package rscpu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDAC = 4'h1, OP_STAC = 4'h2, OP_MVAC = 4'h3,
    OP_MOVR = 4'h4, OP_JUMP = 4'h5, OP_JMPZ = 4'h6, OP_JPNZ = 4'h7,
    OP_ADD  = 4'h8, OP_SUB  = 4'h9, OP_INAC = 4'hA, OP_CLAC = 4'hB,
    OP_AND  = 4'hC, OP_OR   = 4'hD, OP_XOR  = 4'hE, OP_NOT  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000, ALU_SUB = 3'b001, ALU_INAC = 3'b010, ALU_CLAC = 3'b011,
    ALU_AND  = 3'b100, ALU_OR  = 3'b101, ALU_XOR  = 3'b110, ALU_NOT  = 3'b111
  } alu_op_t;
endpackage

// File: rtl/rscpu_alu.sv
// Combinational 8-bit ALU; carry is carry-out for ADD/INAC and borrow for SUB.
module rscpu_alu
  import rscpu_pkg::*;
(
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] r,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);
  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_ADD: begin
        sum    = {1'b0, ac} + {1'b0, r};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      ALU_SUB: begin
        result = ac - r;
        carry  = (ac < r);
      end
      ALU_INAC: begin
        sum    = {1'b0, ac} + 9'd1;
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      ALU_CLAC: result = '0;
      ALU_AND:  result = ac & r;
      ALU_OR:   result = ac | r;
      ALU_XOR:  result = ac ^ r;
      ALU_NOT:  result = ~ac;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/rscpu_datapath.sv
// Accumulator CPU datapath: PC, IR, DR, MA/LA, AC, R, Z (and C when
// RSCPU_CARRY_FLAG_EN is defined), driven entirely by control-unit enables.
module rscpu_datapath
  import rscpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEnableAC,
  input  logic              writeEnableR,
  input  logic              writeEnableMem,
  input  logic              PCEnable,
  input  logic              instructionRegisterEnable,
  input  logic              dataRegisterEnable,
  input  logic              MSBaddressEnable,
  input  logic              LSBaddressEnable,
  input  logic              zeroEnable,
  input  logic              muxSelectPC,
  input  logic              muxSelectZero,
  input  logic              muxSelectAddress,
  input  logic              muxSelectALUtoAC,
  input  logic              muxSelectMEM_or_R_toAC,
  input  logic [DATA_W-1:0] memReadData,
  output logic [DATA_W-1:0] Opcode,
  output logic              z,
  output logic              c,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWrite
);
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir, dr, ma, la, ac, r;
  logic              z_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] ac_next;
  logic [DATA_W-1:0] z_src;

  rscpu_alu u_alu (
    .ac     (ac),
    .r      (r),
    .op     (alu_op_t'(ir[2:0])),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Non-ALU AC source; also the Z source when muxSelectZero is set.
  assign load_val = muxSelectMEM_or_R_toAC ? r : dr;
  assign ac_next  = muxSelectALUtoAC ? alu_result : load_val;
  assign z_src    = muxSelectZero ? load_val : alu_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_PC;
      ir  <= '0;
      dr  <= '0;
      ma  <= '0;
      la  <= '0;
      ac  <= '0;
      r   <= '0;
      z_q <= 1'b1;
    end else begin
      if (PCEnable)                  pc  <= muxSelectPC ? {ma, la} : pc + 16'd1;
      if (instructionRegisterEnable) ir  <= memReadData;
      if (dataRegisterEnable)        dr  <= memReadData;
      if (MSBaddressEnable)          ma  <= memReadData;
      if (LSBaddressEnable)          la  <= memReadData;
      if (writeEnableR)              r   <= ac;
      if (writeEnableAC)             ac  <= ac_next;
      if (zeroEnable)                z_q <= (z_src == '0);
    end
  end

`ifdef RSCPU_CARRY_FLAG_EN
  logic c_q;
  // Only arithmetic ALU updates (ADD/SUB/INAC) touch the carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      c_q <= 1'b0;
    else if (zeroEnable && !muxSelectZero && (ir[2:0] <= 3'd2))
      c_q <= alu_carry;
  end
  assign c = c_q;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
  assign c = 1'b0;
`endif

  assign Opcode       = ir;
  assign z            = z_q;
  assign memAddr      = muxSelectAddress ? {ma, la} : pc;
  assign memWriteData = ac;
  assign memWrite     = writeEnableMem & reset;
endmodule

// File: tb/tb_rscpu_datapath.sv
// Directed-vector bench for rscpu_datapath with hand-computed expectations.
module tb_rscpu_datapath;
`ifdef RSCPU_CARRY_FLAG_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        writeEnableAC, writeEnableR, writeEnableMem;
  logic        PCEnable, instructionRegisterEnable, dataRegisterEnable;
  logic        MSBaddressEnable, LSBaddressEnable, zeroEnable;
  logic        muxSelectPC, muxSelectZero, muxSelectAddress;
  logic        muxSelectALUtoAC, muxSelectMEM_or_R_toAC;
  logic [7:0]  memReadData;
  logic [7:0]  Opcode;
  logic        z, c;
  logic [15:0] memAddr;
  logic [7:0]  memWriteData;
  logic        memWrite;

  int n_checks = 0;
  int n_errors = 0;

  rscpu_datapath dut (
    .clk                       (clk),
    .reset                     (rst_n),
    .writeEnableAC             (writeEnableAC),
    .writeEnableR              (writeEnableR),
    .writeEnableMem            (writeEnableMem),
    .PCEnable                  (PCEnable),
    .instructionRegisterEnable (instructionRegisterEnable),
    .dataRegisterEnable        (dataRegisterEnable),
    .MSBaddressEnable          (MSBaddressEnable),
    .LSBaddressEnable          (LSBaddressEnable),
    .zeroEnable                (zeroEnable),
    .muxSelectPC               (muxSelectPC),
    .muxSelectZero             (muxSelectZero),
    .muxSelectAddress          (muxSelectAddress),
    .muxSelectALUtoAC          (muxSelectALUtoAC),
    .muxSelectMEM_or_R_toAC    (muxSelectMEM_or_R_toAC),
    .memReadData               (memReadData),
    .Opcode                    (Opcode),
    .z                         (z),
    .c                         (c),
    .memAddr                   (memAddr),
    .memWriteData              (memWriteData),
    .memWrite                  (memWrite)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clr();
    writeEnableAC = 0; writeEnableR = 0; writeEnableMem = 0;
    PCEnable = 0; instructionRegisterEnable = 0; dataRegisterEnable = 0;
    MSBaddressEnable = 0; LSBaddressEnable = 0; zeroEnable = 0;
    muxSelectPC = 0; muxSelectZero = 0; muxSelectAddress = 0;
    muxSelectALUtoAC = 0; muxSelectMEM_or_R_toAC = 0;
    memReadData = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic load_dr(input logic [7:0] v);
    memReadData = v; dataRegisterEnable = 1; step();
  endtask

  task automatic load_ir(input logic [7:0] v);
    memReadData = v; instructionRegisterEnable = 1; step();
  endtask

  task automatic load_ma(input logic [7:0] v);
    memReadData = v; MSBaddressEnable = 1; step();
  endtask

  task automatic load_la(input logic [7:0] v);
    memReadData = v; LSBaddressEnable = 1; step();
  endtask

  // LDAC-style: AC <- DR, Z from the load value
  task automatic ac_from_dr();
    writeEnableAC = 1; zeroEnable = 1; muxSelectZero = 1; step();
  endtask

  task automatic set_ac(input logic [7:0] v);
    load_dr(v); ac_from_dr();
  endtask

  task automatic alu_exec(input logic [7:0] op);
    load_ir(op);
    writeEnableAC = 1; muxSelectALUtoAC = 1; zeroEnable = 1; muxSelectZero = 0;
    step();
  endtask

  initial begin
    clr();
    // reset state
    writeEnableMem = 1;
    #12;
    check_eq("rst_pc", memAddr, 16'h0000);
    check_eq("rst_ac", memWriteData, 8'h00);
    check_eq("rst_ir", Opcode, 8'h00);
    check_eq("rst_z", z, 1'b1);
    check_eq("rst_c", c, 1'b0);
    check_eq("rst_memwrite", memWrite, 1'b0);
    muxSelectAddress = 1;
    #1 check_eq("rst_mala", memAddr, 16'h0000);
    clr();
    @(negedge clk) rst_n = 1;

    // build some state, then reset mid-run
    set_ac(8'h5A);
    check_eq("ac_5a", memWriteData, 8'h5A);
    check_eq("z_5a", z, 1'b0);
    load_ir(8'h0F);
    PCEnable = 1; step();
    load_ma(8'h11);
    #2 rst_n = 0;
    writeEnableMem = 1;
    #1;
    check_eq("midrst_ac", memWriteData, 8'h00);
    check_eq("midrst_z", z, 1'b1);
    check_eq("midrst_ir", Opcode, 8'h00);
    check_eq("midrst_pc", memAddr, 16'h0000);
    check_eq("midrst_memwrite", memWrite, 1'b0);
    muxSelectAddress = 1;
    #1 check_eq("midrst_mala", memAddr, 16'h0000);
    clr();
    @(negedge clk) rst_n = 1;
    PCEnable = 1; step();
    check_eq("pc_after_rst", memAddr, 16'h0001);

    // fetch and address register
    load_ir(8'h01);
    check_eq("fetch_ir", Opcode, 8'h01);
    load_ma(8'h12);
    load_la(8'h34);
    muxSelectAddress = 1;
    #1 check_eq("mala_1234", memAddr, 16'h1234);
    check_eq("pc_kept", dut.memAddr === 16'h1234 ? 1'b1 : 1'b0, 1'b1);
    clr();
    #1 check_eq("pc_still_1", memAddr, 16'h0001);

    // LDAC path
    set_ac(8'h42);
    check_eq("ldac_42", memWriteData, 8'h42);
    check_eq("ldac_z0", z, 1'b0);
    set_ac(8'h00);
    check_eq("ldac_00", memWriteData, 8'h00);
    check_eq("ldac_z1", z, 1'b1);

    // ALU: AC=FF, R=01
    set_ac(8'h01);
    writeEnableR = 1; step();
    set_ac(8'hFF);
    check_eq("z_ff", z, 1'b0);
    alu_exec(8'h08);
    check_eq("add_ac", memWriteData, 8'h00);
    check_eq("add_z", z, 1'b1);
    check_eq("add_c", c, CARRY_EN ? 1'b1 : 1'b0);
    alu_exec(8'h09);
    check_eq("sub_ac", memWriteData, 8'hFF);
    check_eq("sub_z", z, 1'b0);
    check_eq("sub_c", c, CARRY_EN ? 1'b1 : 1'b0);
    alu_exec(8'h0C);
    check_eq("and_ac", memWriteData, 8'h01);
    check_eq("and_c_hold", c, CARRY_EN ? 1'b1 : 1'b0);
    alu_exec(8'h0A);
    check_eq("inac_ac", memWriteData, 8'h02);
    check_eq("inac_c", c, 1'b0);
    alu_exec(8'h0E);
    check_eq("xor_ac", memWriteData, 8'h03);
    alu_exec(8'h0D);
    check_eq("or_ac", memWriteData, 8'h03);
    alu_exec(8'h0F);
    check_eq("not_ac", memWriteData, 8'hFC);
    alu_exec(8'h0B);
    check_eq("clac_ac", memWriteData, 8'h00);
    check_eq("clac_z", z, 1'b1);
    // MOVR: AC <- R
    writeEnableAC = 1; muxSelectMEM_or_R_toAC = 1; zeroEnable = 1; muxSelectZero = 1; step();
    check_eq("movr_ac", memWriteData, 8'h01);
    check_eq("movr_z", z, 1'b0);

    // JUMP and PC wrap
    load_ma(8'hFF);
    load_la(8'hFF);
    PCEnable = 1; muxSelectPC = 1; step();
    check_eq("jump_ffff", memAddr, 16'hFFFF);
    PCEnable = 1; step();
    check_eq("pc_wrap", memAddr, 16'h0000);
    load_ma(8'hAB);
    load_la(8'hCD);
    PCEnable = 1; muxSelectPC = 1; MSBaddressEnable = 1; memReadData = 8'h77; step();
    check_eq("jump_old_mala", memAddr, 16'hABCD);
    muxSelectAddress = 1;
    #1 check_eq("ma_77", memAddr, 16'h77CD);
    clr();
    MSBaddressEnable = 1; LSBaddressEnable = 1; memReadData = 8'h5E; step();
    muxSelectAddress = 1;
    #1 check_eq("ma_la_same", memAddr, 16'h5E5E);
    clr();

    // STAC
    set_ac(8'h3C);
    muxSelectAddress = 1; writeEnableMem = 1;
    #1;
    check_eq("stac_we", memWrite, 1'b1);
    check_eq("stac_data", memWriteData, 8'h3C);
    check_eq("stac_addr", memAddr, 16'h5E5E);
    clr();
    #1 check_eq("stac_we_off", memWrite, 1'b0);

    // MVAC with simultaneous AC load: R gets the old AC
    load_dr(8'h99);
    check_eq("dr_no_ac", memWriteData, 8'h3C);
    writeEnableR = 1; writeEnableAC = 1; step();
    check_eq("mvac_ac_new", memWriteData, 8'h99);
    writeEnableAC = 1; muxSelectMEM_or_R_toAC = 1; step();
    check_eq("mvac_r_old", memWriteData, 8'h3C);

    // Z update without AC write
    load_dr(8'h00);
    zeroEnable = 1; muxSelectZero = 1; step();
    check_eq("zonly_z1", z, 1'b1);
    check_eq("zonly_ac", memWriteData, 8'h3C);
    zeroEnable = 1; muxSelectZero = 1; muxSelectMEM_or_R_toAC = 1; step();
    check_eq("zonly_r_z0", z, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
